// File: rtl/register_readout.sv
// Captures a 32-bit register value on RE and streams it out a byte at a time (1-cycle capture latency).
// Ready=0 holds Dbyte/Valid; Done pulses one cycle after the last byte is accepted.
module register_readout #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Din,
  input  logic        RE,
  input  logic        Ready,
  output logic [7:0]  Dbyte,
  output logic        Valid,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] shadow;
  logic [1:0]  cnt;
  logic [1:0]  sel;
  logic        capture;
  logic        xfer;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (RE) begin
          capture   = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (Ready) begin
          xfer = 1'b1;
          if (cnt == 2'd3) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The counter parks at 3 on the final transfer; DONE/IDLE never look at it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      shadow <= 32'h0;
      cnt    <= 2'd0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        shadow <= Din;
        cnt    <= 2'd0;
      end else if (xfer && (cnt != 2'd3)) begin
        cnt <= cnt + 2'd1;
      end
    end
  end

  assign sel = LSB_FIRST ? cnt : ~cnt;

  always_comb begin
    Dbyte = 8'h00;
    if (state == SEND) begin
      case (sel)
        2'd0:    Dbyte = shadow[7:0];
        2'd1:    Dbyte = shadow[15:8];
        2'd2:    Dbyte = shadow[23:16];
        default: Dbyte = shadow[31:24];
      endcase
    end
  end

  assign Valid = (state == SEND);
  assign Busy  = (state != IDLE);
  assign Done  = (state == DONE);

endmodule

// File: tb/tb_register_readout.sv
// Drives an MSB-first (index 0) and an LSB-first (index 1) instance in lockstep;
// a negedge monitor pops expected byte pairs and checks hold/Done behaviour.
module tb_register_readout;

  logic        CLK;
  logic        RST;
  logic [31:0] Din;
  logic        RE;
  logic        Ready;
  logic [7:0]  dbyte [2];
  logic        valid [2];
  logic        busy  [2];
  logic        done  [2];

  register_readout #(.LSB_FIRST(1'b0)) u_msb (
    .CLK(CLK), .RST(RST), .Din(Din), .RE(RE), .Ready(Ready),
    .Dbyte(dbyte[0]), .Valid(valid[0]), .Busy(busy[0]), .Done(done[0])
  );

  register_readout #(.LSB_FIRST(1'b1)) u_lsb (
    .CLK(CLK), .RST(RST), .Din(Din), .RE(RE), .Ready(Ready),
    .Dbyte(dbyte[1]), .Valid(valid[1]), .Busy(busy[1]), .Done(done[1])
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;
  int exp_done = 0;
  int done_cnt [2] = '{0, 0};

  // Each entry: {msb-first expected byte, lsb-first expected byte}
  logic [15:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++)
      exp_q.push_back({w[8*(3-i) +: 8], w[8*i +: 8]});
  endtask

  // Issue RE with word w; returns in the first SEND cycle after checking latency.
  task automatic start_read(input logic [31:0] w);
    Din = w;
    RE  = 1'b1;
    push_word(w);
    tick();
    RE = 1'b0;
    check("lat_valid_msb", {31'd0, valid[0]}, 32'd1);
    check("lat_valid_lsb", {31'd0, valid[1]}, 32'd1);
    check("lat_byte_msb", {24'd0, dbyte[0]}, {24'd0, w[31:24]});
    check("lat_byte_lsb", {24'd0, dbyte[1]}, {24'd0, w[7:0]});
  endtask

  task automatic expect_done();
    for (int k = 0; k < 2; k++) begin
      check("done_pulse", {31'd0, done[k]}, 32'd1);
      check("done_busy", {31'd0, busy[k]}, 32'd1);
      check("done_valid", {31'd0, valid[k]}, 32'd0);
    end
    exp_done++;
  endtask

  task automatic expect_idle(input string name);
    for (int k = 0; k < 2; k++) begin
      check({name, "_valid"}, {31'd0, valid[k]}, 32'd0);
      check({name, "_busy"}, {31'd0, busy[k]}, 32'd0);
      check({name, "_done"}, {31'd0, done[k]}, 32'd0);
      check({name, "_dbyte"}, {24'd0, dbyte[k]}, 32'd0);
    end
  endtask

  // Monitor: transfers, stall stability, Done timing.
  logic       stall_v [2] = '{1'b0, 1'b0};
  logic [7:0] stall_b [2];
  int         last_xfer_cyc = -10;

  always @(negedge CLK) begin
    if (RST) begin
      stall_v[0] = 1'b0;
      stall_v[1] = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (stall_v[k]) begin
          check("hold_valid", {31'd0, valid[k]}, 32'd1);
          check("hold_dbyte", {24'd0, dbyte[k]}, {24'd0, stall_b[k]});
        end
      end
      if (valid[1] && Ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", {24'd0, dbyte[1]}, 32'hFFFF_FFFF);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("xfer_valid_msb", {31'd0, valid[0]}, 32'd1);
          check("xfer_byte_msb", {24'd0, dbyte[0]}, {24'd0, e[15:8]});
          check("xfer_byte_lsb", {24'd0, dbyte[1]}, {24'd0, e[7:0]});
        end
        last_xfer_cyc = cyc;
      end
      for (int k = 0; k < 2; k++) begin
        if (done[k]) begin
          done_cnt[k]++;
          check("done_after_last", cyc, last_xfer_cyc + 1);
          check("done_q_empty", exp_q.size(), 0);
        end
        stall_v[k] = valid[k] && !Ready;
        stall_b[k] = dbyte[k];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

  logic [0:6] pat;

  initial begin
    RST   = 1'b1;
    RE    = 1'b0;
    Ready = 1'b0;
    Din   = 32'h0;
    repeat (3) tick();
    expect_idle("reset");
    RST   = 1'b0;
    Ready = 1'b1;

    // LSB instance: EF,BE,AD,DE; MSB instance: DE,AD,BE,EF
    start_read(32'hDEADBEEF);
    repeat (4) tick();
    expect_done();
    tick();
    expect_idle("post_done1");

    // MSB instance: 12,34,56,78
    start_read(32'h12345678);
    repeat (4) tick();
    expect_done();
    tick();
    expect_idle("post_done2");

    // Ready pattern 1,0,0,1,1,0,1 gives exactly four transfers
    Ready = 1'b0;
    start_read(32'hA5A5_0F0F);
    pat = 7'b1001101;
    for (int i = 0; i < 7; i++) begin
      Ready = pat[i];
      tick();
    end
    expect_done();
    Ready = 1'b1;
    tick();
    expect_idle("post_done3");

    // Din change and RE re-pulse mid-readout must not disturb it
    start_read(32'h87654321);
    tick();
    Din = 32'hFFFF_FFFF;
    RE  = 1'b1;
    tick();
    tick();
    RE = 1'b0;
    tick();
    expect_done();
    tick();
    expect_idle("no_requeue_a");
    tick();
    expect_idle("no_requeue_b");

    // Abort after the second byte is accepted
    start_read(32'hCAFEBABE);
    tick();
    tick();
    RST = 1'b1;
    tick();
    expect_idle("abort");
    exp_q.delete();
    RST = 1'b0;
    start_read(32'h0000_0001);
    repeat (4) tick();
    expect_done();
    tick();
    expect_idle("post_abort");

    // RE held high: a capture every 6 cycles
    Din = 32'h11223344;
    RE  = 1'b1;
    for (int r = 0; r < 3; r++) begin
      int c0;
      push_word(32'h11223344);
      c0 = cyc;
      tick();
      check("b2b_valid", {31'd0, valid[1]}, 32'd1);
      repeat (4) tick();
      expect_done();
      check("b2b_period", cyc - c0, 5);
      if (r == 2) RE = 1'b0;
      tick();
      expect_idle("b2b_idle");
    end

    repeat (3) tick();
    expect_idle("final");
    check("final_q_empty", exp_q.size(), 0);
    check("done_count_msb", done_cnt[0], exp_done);
    check("done_count_lsb", done_cnt[1], exp_done);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
